cgra_config_loader: RTL and testbench
=====================================

# cgra_config_loader

Fetches the CGRA instruction image from global memory over the kernel's AXI4 master read channel and writes it, one phit per configuration row, into the per-column configuration memories. After the full image (DEPTH_CONFIG rows) has landed, it pulses `cgra_start` to launch the array. It sits between the kernel control block (`start`/`base_addr`) and the CGRA column instruction RAMs, replacing file-driven loading in the bench.

## Interface
Parameters:
- NUM_COL, 16, number of CGRA columns
- DWIDTH_INT, 32, instruction word width per column
- PHIT_SIZE, 512, AXI data width; must equal NUM_COL*DWIDTH_INT
- DEPTH_CONFIG, 64, configuration rows per image; multiple of BURST_LEN
- BURST_LEN, 16, beats per AXI burst (1..256)
- ADDR_WIDTH, 64, AXI address width

Ports:
- `ap_clk`, in, 1, sole clock
- `ap_rst_n`, in, 1, reset; asynchronous assert, active-low
- `start`, in, 1, one-cycle load request
- `base_addr`, in, ADDR_WIDTH, byte address of row 0; sampled on accepted `start`; PHIT_SIZE/8 aligned
- `busy`, out, 1, high from accepted `start` until `done`
- `done`, out, 1, one-cycle pulse at end of load (success or error)
- `error`, out, 1, sticky error flag; cleared on the next accepted `start`
- `m00_axi_arvalid`, out, 1, AR valid
- `m00_axi_arready`, in, 1, AR ready
- `m00_axi_araddr`, out, ADDR_WIDTH, burst start address
- `m00_axi_arlen`, out, 8, constant BURST_LEN-1
- `m00_axi_rvalid`, in, 1, R valid
- `m00_axi_rready`, out, 1, R ready
- `m00_axi_rdata`, in, PHIT_SIZE, R data
- `m00_axi_rlast`, in, 1, R last
- `m00_axi_rresp`, in, 2, R response
- `cfg_we`, out, 1, configuration row write strobe
- `cfg_addr`, out, $clog2(DEPTH_CONFIG), row index
- `cfg_wdata`, out, PHIT_SIZE, row data; column c takes bits [DWIDTH_INT*(c+1)-1 : DWIDTH_INT*c]
- `cgra_start`, out, 1, one-cycle launch pulse

## Operation
- FSM states: IDLE, AR, R, FIRE.
- IDLE: `start` latches `base_addr` into `cur_addr`, zeroes `row_cnt`/`beat_cnt`, clears `error`, sets `busy`, and moves to AR. `start` is ignored in any other state.
- AR: `arvalid`=1 and `araddr`=`cur_addr`. On `arready` the FSM moves to R.
- R: `rready`=1. On each `rvalid&rready` beat:
  - registered write: `cfg_we`=1, `cfg_addr`=`row_cnt`, `cfg_wdata`=`rdata`
  - `row_cnt`++ and `beat_cnt`++
- On the beat with `beat_cnt==BURST_LEN-1`:
  - `beat_cnt`←0
  - if `row_cnt+1==DEPTH_CONFIG`, go to FIRE
  - otherwise `cur_addr`+=BURST_LEN*PHIT_SIZE/8 and go to AR
- FIRE: `cgra_start`=1 and `done`=1 for one cycle; `busy`←0; return to IDLE. On error, `cgra_start` stays 0 and `done` still pulses.
- Only one AR is outstanding at a time; no read interleaving.
- `row_cnt` never wraps. The image ends exactly at DEPTH_CONFIG rows.

## Timing
- Reset values: all outputs 0. `m00_axi_arlen` is the constant BURST_LEN-1. The FSM is in IDLE.
- `start`→`arvalid`: 1 cycle.
- `cfg_we` is asserted 1 cycle after the R handshake. Back-to-back beats give back-to-back writes.
- Last R handshake→`cgra_start`/`done`: 2 cycles (write in cycle+1, FIRE in cycle+2).
- `arvalid` is held until `arready`, and `araddr` is stable while valid.
- Asserting `ap_rst_n` low mid-load aborts immediately: all outputs go to 0 and any partial image is left in the config RAMs.
- When `start` and `done` fall in the same cycle, `start` is ignored because the FSM is not yet in IDLE.

## Configuration
- `CFG_LOADER_CHECK_EN` defined:
  - `rresp`≠0 on any beat sets `error`
  - `rlast` asserted with `beat_cnt`≠BURST_LEN-1, or deasserted with `beat_cnt`==BURST_LEN-1, sets `error`
  - the burst still completes by count, and FIRE suppresses `cgra_start`
- Not defined: `rresp` and `rlast` are ignored, bursts end by counting only, and `error` is tied 0.

## Test plan
- Nominal, DEPTH_CONFIG=64, BURST_LEN=16, base 0x1000, row k word c = k*16+c:
  - required: 4 ARs at 0x1000/0x1400/0x1800/0x1C00
  - 64 `cfg_we` with matching addr/data
  - `cgra_start` and `done` pulse 2 cycles after the 64th beat; `error`=0
- AR backpressure: `arready` low for 5 cycles per burst -> `araddr`/`arvalid` held stable; result identical to nominal.
- R gaps: `rvalid` randomly low 50% of cycles -> exactly 64 writes, in order, with no duplicates.
- `start` repulsed mid-load at row 20 -> ignored; a single `done` at completion.
- Reset asserted at row 30 -> all outputs 0 within the same cycle. A new `start` reloads from row 0.
- With `CFG_LOADER_CHECK_EN`:
  - `rresp`=2 on row 5 -> `error`=1, `done` pulses, `cgra_start` stays 0
  - early `rlast` at beat 10 -> `error`=1
  - next `start` clears `error`

Source files
------------

// File: rtl/cgra_config_loader.sv
// cgra_config_loader: reads the CGRA instruction image over AXI4 in fixed bursts and writes one row per beat into the column config RAMs.
// Optional response/last checking is compiled in with `define CFG_LOADER_CHECK_EN.
module cgra_config_loader #(
  parameter int NUM_COL      = 16,
  parameter int DWIDTH_INT   = 32,
  parameter int PHIT_SIZE    = 512,
  parameter int DEPTH_CONFIG = 64,
  parameter int BURST_LEN    = 16,
  parameter int ADDR_WIDTH   = 64
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  output logic [ADDR_WIDTH-1:0]           m00_axi_araddr,
  output logic [7:0]                      m00_axi_arlen,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready,
  input  logic [PHIT_SIZE-1:0]            m00_axi_rdata,
  input  logic                            m00_axi_rlast,
  input  logic [1:0]                      m00_axi_rresp,
  output logic                            cfg_we,
  output logic [$clog2(DEPTH_CONFIG)-1:0] cfg_addr,
  output logic [PHIT_SIZE-1:0]            cfg_wdata,
  output logic                            cgra_start
);

  localparam int ROW_W  = $clog2(DEPTH_CONFIG);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * PHIT_SIZE / 8);
  localparam logic [ROW_W-1:0]      LAST_ROW    = ROW_W'(DEPTH_CONFIG - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

  if (PHIT_SIZE != NUM_COL * DWIDTH_INT) begin : g_bad_phit
    $error("PHIT_SIZE must equal NUM_COL*DWIDTH_INT");
  end

  typedef enum logic [1:0] {IDLE, AR, R, FIRE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ROW_W-1:0]        row_cnt;
  logic [BEAT_W-1:0]       beat_cnt;
  logic                    start_acc;
  logic                    beat_hs;
  logic                    last_beat;
  logic                    fire;
  logic                    wr_vld_p1;
  logic [ROW_W-1:0]        wr_addr_p1;
  logic [PHIT_SIZE-1:0]    wr_data_p1;

  assign start_acc = (state_q == IDLE) && start;
  assign beat_hs   = (state_q == R) && m00_axi_rvalid;
  assign last_beat = beat_hs && (beat_cnt == LAST_BEAT);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FIRE waits out the final row write so the launch lands two cycles after the last beat
  always_comb begin
    state_d         = state_q;
    m00_axi_arvalid = 1'b0;
    m00_axi_rready  = 1'b0;
    fire            = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = AR;
      AR: begin
        m00_axi_arvalid = 1'b1;
        if (m00_axi_arready) state_d = R;
      end
      R: begin
        m00_axi_rready = 1'b1;
        if (last_beat) state_d = (row_cnt == LAST_ROW) ? FIRE : AR;
      end
      FIRE: begin
        if (!wr_vld_p1) begin
          fire    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cur_addr <= '0;
      row_cnt  <= '0;
      beat_cnt <= '0;
    end else if (start_acc) begin
      cur_addr <= base_addr;
      row_cnt  <= '0;
      beat_cnt <= '0;
    end else if (beat_hs) begin
      if (last_beat) begin
        beat_cnt <= '0;
        if (row_cnt != LAST_ROW) begin
          cur_addr <= cur_addr + BURST_BYTES;
          row_cnt  <= row_cnt + 1'b1;
        end
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        row_cnt  <= row_cnt + 1'b1;
      end
    end
  end

  // Stage p1: registered config RAM write
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= beat_hs;
      if (beat_hs) begin
        wr_addr_p1 <= row_cnt;
        wr_data_p1 <= m00_axi_rdata;
      end
    end
  end

`ifdef CFG_LOADER_CHECK_EN
  logic error_q;
  logic beat_bad;

  assign beat_bad = (m00_axi_rresp != 2'b00) || (m00_axi_rlast != (beat_cnt == LAST_BEAT));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                error_q <= 1'b0;
    else if (start_acc)           error_q <= 1'b0;
    else if (beat_hs && beat_bad) error_q <= 1'b1;
  end

  assign error = error_q;
`else
  logic unused_resp;
  assign unused_resp = ^{m00_axi_rresp, m00_axi_rlast};
  assign error       = 1'b0;
`endif

  assign busy           = (state_q != IDLE);
  assign done           = fire;
  assign cgra_start     = fire && !error;
  assign m00_axi_araddr = cur_addr;
  assign m00_axi_arlen  = 8'(BURST_LEN - 1);
  assign cfg_we         = wr_vld_p1;
  assign cfg_addr       = wr_addr_p1;
  assign cfg_wdata      = wr_data_p1;

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader: an AXI read slave model serves row k word c = k*16+c and a monitor logs config writes.
`timescale 1ns/1ps
module tb_cgra_config_loader;
  localparam int NUM_COL      = 16;
  localparam int DWIDTH_INT   = 32;
  localparam int PHIT_SIZE    = 512;
  localparam int DEPTH_CONFIG = 64;
  localparam int BURST_LEN    = 16;
  localparam int ADDR_WIDTH   = 64;

  logic                  ap_clk;
  logic                  ap_rst_n;
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  busy, done, error;
  logic                  arvalid, arready, rvalid, rready, rlast;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [PHIT_SIZE-1:0]  rdata;
  logic [1:0]            rresp;
  logic                  cfg_we;
  logic [5:0]            cfg_addr;
  logic [PHIT_SIZE-1:0]  cfg_wdata;
  logic                  cgra_start;

  cgra_config_loader #(
    .NUM_COL(NUM_COL), .DWIDTH_INT(DWIDTH_INT), .PHIT_SIZE(PHIT_SIZE),
    .DEPTH_CONFIG(DEPTH_CONFIG), .BURST_LEN(BURST_LEN), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .error(error),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready), .m00_axi_araddr(araddr),
    .m00_axi_arlen(arlen), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .m00_axi_rdata(rdata), .m00_axi_rlast(rlast), .m00_axi_rresp(rresp),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cgra_start(cgra_start)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int errors = 0;
  int checks = 0;

  // slave model controls
  logic [63:0] tb_base = 64'h1000;
  int ar_wait = 0;
  int gap_en = 0;
  int inject_row = -1;
  int early_beat = -1;

  // slave model state and logs
  bit          burst_act = 0;
  bit          prev_ar = 0;
  bit          prev_r = 0;
  logic [63:0] raddr = '0;
  logic [63:0] prev_araddr = '0;
  logic [63:0] held_addr = '0;
  int beat = 0, wcnt = 0, row = 0, cyc = 0;
  int wr_count = 0, mon_bad = 0, ar_cnt = 0, done_cnt = 0, cgra_cnt = 0;
  int done_cyc = 0, last_hs_cyc = 0, stab_err = 0;
  logic [63:0] ar_log [8];

  function automatic logic [511:0] row_data(input int k);
    logic [511:0] r;
    r = '0;
    for (int c = 0; c < 16; c++) r[32*c +: 32] = 32'(k * 16 + c);
    return r;
  endfunction

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (cfg_we) begin
        if (wr_count >= DEPTH_CONFIG || cfg_addr !== wr_count[5:0] || cfg_wdata !== row_data(wr_count))
          mon_bad++;
        wr_count++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cgra_start) cgra_cnt++;
      if (!ap_rst_n) begin
        burst_act = 0; beat = 0; wcnt = 0; prev_ar = 0; prev_r = 0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end else begin
        if (prev_ar) begin
          burst_act = 1; raddr = prev_araddr; beat = 0; wcnt = 0;
          if (ar_cnt < 8) ar_log[ar_cnt] = prev_araddr;
          ar_cnt++;
        end
        if (prev_r) begin
          beat++;
          last_hs_cyc = cyc;
          if (beat == BURST_LEN) begin
            burst_act = 0;
            wcnt = 0;
          end
        end
        arready = 1'b0;
        if (arvalid && !burst_act) begin
          if (wcnt > 0 && araddr !== held_addr) stab_err++;
          if (wcnt == 0) held_addr = araddr;
          if (wcnt >= ar_wait) arready = 1'b1;
          wcnt++;
        end
        rvalid = burst_act && (gap_en == 0 || $urandom_range(0, 1) == 1);
        row    = int'((raddr - tb_base) >> 6) + beat;
        rdata  = row_data(row);
        rlast  = (early_beat >= 0) ? (beat == early_beat) : (beat == BURST_LEN - 1);
        rresp  = (burst_act && row == inject_row) ? 2'd2 : 2'd0;
        prev_ar     = arvalid && arready;
        prev_araddr = araddr;
        prev_r      = rvalid && rready;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_count = 0; mon_bad = 0; ar_cnt = 0; done_cnt = 0; cgra_cnt = 0;
    done_cyc = 0; last_hs_cyc = 0; stab_err = 0;
    for (int i = 0; i < 8; i++) ar_log[i] = '0;
  endtask

  task automatic do_start(input logic [63:0] a);
    @(negedge ap_clk);
    start = 1'b1;
    base_addr = a;
    @(negedge ap_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk({tag, " done_seen"}, 64'(done_cnt != 0), 64'd1);
  endtask

  task automatic wait_rows(input int rows, input string tag);
    int n;
    n = 0;
    while (wr_count < rows && n < 1000) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk({tag, " rows_reached"}, 64'(wr_count), 64'(rows));
  endtask

  task automatic check_full(input string tag, input logic [63:0] b);
    chk({tag, " writes"}, 64'(wr_count), 64'd64);
    chk({tag, " write_order_data"}, 64'(mon_bad), 64'd0);
    chk({tag, " ar_count"}, 64'(ar_cnt), 64'd4);
    for (int i = 0; i < 4; i++)
      chk({tag, " ar_addr"}, ar_log[i], b + 64'(i) * 64'h400);
    chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, " done_latency"}, 64'(done_cyc - last_hs_cyc), 64'd1);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    ap_rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    repeat (3) @(negedge ap_clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst error", 64'(error), 64'd0);
    chk("rst arvalid", 64'(arvalid), 64'd0);
    chk("rst araddr", araddr, 64'd0);
    chk("rst arlen", 64'(arlen), 64'd15);
    chk("rst rready", 64'(rready), 64'd0);
    chk("rst cfg_we", 64'(cfg_we), 64'd0);
    chk("rst cfg_addr", 64'(cfg_addr), 64'd0);
    chk("rst cgra_start", 64'(cgra_start), 64'd0);
    ap_rst_n = 1'b1;

    // nominal load
    tb_base = 64'h1000;
    clear_log();
    do_start(64'h1000);
    chk("nom arvalid_after_start", 64'(arvalid), 64'd1);
    chk("nom busy_after_start", 64'(busy), 64'd1);
    chk("nom araddr_first", araddr, 64'h1000);
    wait_done("nom");
    check_full("nom", 64'h1000);
    chk("nom cgra_start_count", 64'(cgra_cnt), 64'd1);
    chk("nom error", 64'(error), 64'd0);

    // AR backpressure
    ar_wait = 5;
    clear_log();
    do_start(64'h1000);
    wait_done("bp");
    check_full("bp", 64'h1000);
    chk("bp araddr_stable", 64'(stab_err), 64'd0);
    chk("bp cgra_start_count", 64'(cgra_cnt), 64'd1);
    ar_wait = 0;

    // R gaps
    gap_en = 1;
    tb_base = 64'h2000;
    clear_log();
    do_start(64'h2000);
    wait_done("gap");
    check_full("gap", 64'h2000);
    chk("gap cgra_start_count", 64'(cgra_cnt), 64'd1);
    gap_en = 0;

    // start repeated mid-load is ignored
    tb_base = 64'h1000;
    clear_log();
    do_start(64'h1000);
    wait_rows(20, "restart");
    do_start(64'h9000);
    wait_done("restart");
    check_full("restart", 64'h1000);
    repeat (20) @(posedge ap_clk);
    #1;
    chk("restart single_done", 64'(done_cnt), 64'd1);

    // reset mid-load, then reload from row 0
    clear_log();
    do_start(64'h1000);
    wait_rows(30, "midrst");
    ap_rst_n = 1'b0;
    #1;
    chk("midrst arvalid", 64'(arvalid), 64'd0);
    chk("midrst rready", 64'(rready), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst cfg_we", 64'(cfg_we), 64'd0);
    chk("midrst cfg_addr", 64'(cfg_addr), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    clear_log();
    do_start(64'h1000);
    wait_done("reload");
    check_full("reload", 64'h1000);
    chk("reload cgra_start_count", 64'(cgra_cnt), 64'd1);

`ifdef CFG_LOADER_CHECK_EN
    // bad response on row 5
    inject_row = 5;
    clear_log();
    do_start(64'h1000);
    wait_done("rresp");
    chk("rresp error", 64'(error), 64'd1);
    chk("rresp cgra_start_count", 64'(cgra_cnt), 64'd0);
    chk("rresp done_count", 64'(done_cnt), 64'd1);
    chk("rresp writes", 64'(wr_count), 64'd64);
    inject_row = -1;

    // early rlast at beat 10
    early_beat = 10;
    clear_log();
    do_start(64'h1000);
    chk("rlast error_cleared_by_start", 64'(error), 64'd0);
    wait_done("rlast");
    chk("rlast error", 64'(error), 64'd1);
    chk("rlast cgra_start_count", 64'(cgra_cnt), 64'd0);
    chk("rlast writes", 64'(wr_count), 64'd64);
    early_beat = -1;

    // clean load after an error
    clear_log();
    do_start(64'h1000);
    chk("clean error_cleared_by_start", 64'(error), 64'd0);
    wait_done("clean");
    chk("clean error", 64'(error), 64'd0);
    chk("clean cgra_start_count", 64'(cgra_cnt), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
